// File: rtl/exec_pkg.sv
// ============================================================================
// exec_pkg : opcode and state types shared by the execution unit
// Rev 1.0
// ============================================================================
`default_nettype none

package exec_pkg;

  typedef enum logic [4:0] {
    ALUOP_ADD   = 5'h00,
    ALUOP_SUB   = 5'h01,
    ALUOP_AND   = 5'h02,
    ALUOP_OR    = 5'h03,
    ALUOP_NOR   = 5'h04,
    ALUOP_XOR   = 5'h05,
    ALUOP_SLL   = 5'h06,
    ALUOP_SRL   = 5'h07,
    ALUOP_SRA   = 5'h08,
    ALUOP_SLT   = 5'h09,
    ALUOP_SLTU  = 5'h0A,
    ALUOP_SETB  = 5'h0B,
    ALUOP_CLRB  = 5'h0C,
    ALUOP_SLLV  = 5'h0D,
    ALUOP_SRLV  = 5'h0E,
    ALUOP_SRAV  = 5'h0F,
    MDUOP_MUL   = 5'h10,
    MDUOP_MULHU = 5'h11,
    MDUOP_DIVU  = 5'h12,
    MDUOP_REMU  = 5'h13
  } exec_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exec_state_e;

  localparam logic [4:0] c_mdu_first     = 5'h10;
  localparam logic [4:0] c_mdu_last      = 5'h13;
  localparam logic [4:0] c_illegal_first = 5'h14;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op >= c_mdu_first) && (op <= c_mdu_last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_if.sv
// ============================================================================
// exec_if : request/result handshake bundle between issue and exec_unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             i_valid;
  logic             o_ready;
  logic [4:0]       i_opcode;
  logic [WIDTH-1:0] i_wordA;
  logic [WIDTH-1:0] i_wordB;
  logic [SHW-1:0]   i_shamt;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_illegal;

  modport master (
    output i_valid, i_opcode, i_wordA, i_wordB, i_shamt, i_ready,
    input  o_ready, o_valid, o_result, o_illegal
  );

  modport slave (
    input  i_valid, i_opcode, i_wordA, i_wordB, i_shamt, i_ready,
    output o_ready, o_valid, o_result, o_illegal
  );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : bit-serial unsigned multiply / restoring divide, one bit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;

  // acc holds the product high half / partial remainder; opr holds the
  // multiplier shifting out / quotient shifting in.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opr_d     = opr_q;
    div_d     = div_q;
    w_sum     = '0;
    w_shifted = '0;
    if (i_start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH - 1);
      op_d   = i_op;
      acc_d  = '0;
      opr_d  = i_a;
      div_d  = i_b;
    end else if (busy_q) begin
      if (!op_q[1]) begin
        w_sum          = {1'b0, acc_q} + (opr_q[0] ? {1'b0, div_q} : '0);
        {acc_d, opr_d} = {w_sum, opr_q[WIDTH-1:1]};
      end else begin
        // A zero divisor always "fits", giving all-ones quotient and remainder A
        w_shifted = {acc_q, opr_q[WIDTH-1]};
        if (w_shifted >= {1'b0, div_q}) begin
          acc_d = w_shifted[WIDTH-1:0] - div_q;
          opr_d = {opr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = w_shifted[WIDTH-1:0];
          opr_d = {opr_q[WIDTH-2:0], 1'b0};
        end
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      acc_q  <= '0;
      opr_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      opr_q  <= opr_d;
      div_q  <= div_d;
    end
  end

  // Result reflects the step being taken this cycle, valid alongside o_done
  assign o_done   = busy_q && (cnt_q == '0);
  assign o_result = op_q[0] ? acc_d : opr_d;

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
// exec_unit : single-cycle ALU plus iterative MDU behind a valid/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic   i_clk,
  input  logic   i_rst,
  exec_if.slave  bus
);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  exec_state_e      state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_mdu_start;
  logic             w_mdu_done;
  logic [WIDTH-1:0] w_mdu_res;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_sh;
  logic [SHW-1:0]   w_shv;

  assign w_a   = bus.i_wordA;
  assign w_b   = bus.i_wordB;
  assign w_sh  = bus.i_shamt;
  assign w_shv = bus.i_wordB[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    case (exec_op_e'(bus.i_opcode))
      ALUOP_ADD:  w_alu_res = w_a + w_b;
      ALUOP_SUB:  w_alu_res = w_a - w_b;
      ALUOP_AND:  w_alu_res = w_a & w_b;
      ALUOP_OR:   w_alu_res = w_a | w_b;
      ALUOP_NOR:  w_alu_res = ~(w_a | w_b);
      ALUOP_XOR:  w_alu_res = w_a ^ w_b;
      ALUOP_SLL:  w_alu_res = w_a << w_sh;
      ALUOP_SRL:  w_alu_res = w_a >> w_sh;
      ALUOP_SRA:  w_alu_res = $signed(w_a) >>> w_sh;
      ALUOP_SLT:  w_alu_res = WIDTH'($signed(w_a) < $signed(w_b));
      ALUOP_SLTU: w_alu_res = WIDTH'(w_a < w_b);
      ALUOP_SETB: w_alu_res = w_a | (c_one << w_sh);
      ALUOP_CLRB: w_alu_res = w_a & ~(c_one << w_sh);
      ALUOP_SLLV: w_alu_res = w_a << w_shv;
      ALUOP_SRLV: w_alu_res = w_a >> w_shv;
      ALUOP_SRAV: w_alu_res = $signed(w_a) >>> w_shv;
      default:    w_alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    w_mdu_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          if (is_mdu_op(bus.i_opcode)) begin
            w_mdu_start = 1'b1;
            state_d     = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            result_d  = w_alu_res;
            illegal_d = (bus.i_opcode >= c_illegal_first);
          end
        end
      end
      ST_BUSY: begin
        if (w_mdu_done) begin
          state_d   = ST_DONE;
          valid_d   = 1'b1;
          result_d  = w_mdu_res;
          illegal_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_mdu_start),
    .i_op     (bus.i_opcode[1:0]),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_done   (w_mdu_done),
    .o_result (w_mdu_res)
  );

  assign bus.o_ready   = (state_q == ST_IDLE);
  assign bus.o_valid   = valid_q;
  assign bus.o_result  = result_q;
  assign bus.o_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
// tb_exec_unit : scoreboard bench for exec_unit at WIDTH=32
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_unit;
  localparam int WIDTH = 32;
  localparam int BOUND = 200;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  exec_if #(.WIDTH(WIDTH)) bus ();

  exec_unit #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge, wait for acceptance, return just after the accept edge
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] er, input logic eil,
                      input int elat);
    int w;
    exp_q.push_back('{res: er, ill: eil, lat: elat});
    bus.i_valid  = 1'b1;
    bus.i_opcode = op;
    bus.i_wordA  = a;
    bus.i_wordB  = b;
    bus.i_shamt  = sh;
    w = 0;
    while (!bus.o_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (w == BOUND) check_eq("accept_timeout", 64'(w), 64'(0));
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_wordA = 32'hDEAD_BEEF;
    bus.i_wordB = 32'h0BAD_F00D;
  endtask

  // Wait for o_valid, pop the oldest expectation and compare
  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.o_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_valid"}, 64'(bus.o_valid), 64'(1));
    check_eq({tag, "_res"}, 64'(bus.o_result), 64'(e.res));
    check_eq({tag, "_ill"}, 64'(bus.o_illegal), 64'(e.ill));
    check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
    if (bus.i_ready) begin
      @(negedge clk);
      check_eq({tag, "_drop"}, 64'(bus.o_valid), 64'(0));
    end
  endtask

  task automatic op_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                          input logic eil, input int elat);
    send(op, a, b, sh, er, eil, elat);
    collect(tag);
  endtask

  initial begin
    int seen;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;
    bus.i_opcode = '0;
    bus.i_wordA  = '0;
    bus.i_wordB  = '0;
    bus.i_shamt  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_valid", 64'(bus.o_valid), 64'(0));
    check_eq("rst_result", 64'(bus.o_result), 64'(0));
    check_eq("rst_illegal", 64'(bus.o_illegal), 64'(0));
    check_eq("rst_ready", 64'(bus.o_ready), 64'(1));

    // Single-cycle ALU sweep
    op_check("add_wrap", 5'h00, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1);
    op_check("sub", 5'h01, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b0, 1);
    op_check("and", 5'h02, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 32'h00F0_F000, 1'b0, 1);
    op_check("or", 5'h03, 32'hF000_000F, 32'h0000_FF00, 5'd0, 32'hF000_FF0F, 1'b0, 1);
    op_check("nor", 5'h04, 32'h0, 32'h0000_00FF, 5'd0, 32'hFFFF_FF00, 1'b0, 1);
    op_check("xor", 5'h05, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h5555_5555, 1'b0, 1);
    op_check("sll", 5'h06, 32'h1, 32'h0, 5'd31, 32'h8000_0000, 1'b0, 1);
    op_check("srl", 5'h07, 32'h8000_0000, 32'h0, 5'd4, 32'h0800_0000, 1'b0, 1);
    op_check("sra", 5'h08, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 1'b0, 1);
    op_check("slt", 5'h09, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1);
    op_check("sltu", 5'h0A, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1);
    op_check("setb", 5'h0B, 32'h0, 32'h0, 5'd31, 32'h8000_0000, 1'b0, 1);
    op_check("clrb", 5'h0C, 32'hFF, 32'h0, 5'd0, 32'hFE, 1'b0, 1);
    op_check("sllv", 5'h0D, 32'h1, 32'd35, 5'd0, 32'h8, 1'b0, 1);
    op_check("srlv", 5'h0E, 32'h8000_0000, 32'd4, 5'd9, 32'h0800_0000, 1'b0, 1);
    op_check("srav", 5'h0F, 32'h8000_0000, 32'd8, 5'd0, 32'hFF80_0000, 1'b0, 1);

    // Iterative multiply / divide
    op_check("mul_big", 5'h10, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0, 1'b0, 33);
    op_check("mulhu_big", 5'h11, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h1, 1'b0, 33);
    op_check("mul_7x6", 5'h10, 32'd7, 32'd6, 5'd0, 32'd42, 1'b0, 33);
    op_check("mulhu_max", 5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, 33);
    op_check("divu", 5'h12, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 33);
    op_check("remu", 5'h13, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, 33);
    op_check("divu_z", 5'h12, 32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 33);
    op_check("remu_z", 5'h13, 32'd5, 32'd0, 5'd0, 32'd5, 1'b0, 33);

    // Back-pressure: result held while a second request waits
    bus.i_ready = 1'b0;
    send(5'h00, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1);
    collect("bp_first");
    bus.i_valid  = 1'b1;
    bus.i_opcode = 5'h00;
    bus.i_wordA  = 32'd1;
    bus.i_wordB  = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold_res", 64'(bus.o_result), 64'(7));
      check_eq("bp_hold_valid", 64'(bus.o_valid), 64'(1));
      check_eq("bp_hold_ready", 64'(bus.o_ready), 64'(0));
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_valid", 64'(bus.o_valid), 64'(0));
    check_eq("bp_rel_ready", 64'(bus.o_ready), 64'(1));
    exp_q.push_back('{res: 32'd3, ill: 1'b0, lat: 1});
    @(negedge clk);
    bus.i_valid = 1'b0;
    check_eq("bp_accept", 64'(bus.o_ready), 64'(0));
    collect("bp_second");

    // Reset in the middle of a divide
    bus.i_valid  = 1'b1;
    bus.i_opcode = 5'h12;
    bus.i_wordA  = 32'd1000;
    bus.i_wordB  = 32'd3;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("mid_busy_ready", 64'(bus.o_ready), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ready", 64'(bus.o_ready), 64'(1));
    check_eq("mid_rst_valid", 64'(bus.o_valid), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) seen++;
    end
    check_eq("mid_rst_novalid", 64'(seen), 64'(0));
    op_check("post_rst_add", 5'h00, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1);

    // Undefined opcode, then a legal one clears the flag
    op_check("illegal", 5'h1A, 32'h1234_5678, 32'h1, 5'd3, 32'h0, 1'b1, 1);
    op_check("illegal_hi", 5'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 1);
    op_check("after_ill", 5'h03, 32'h10, 32'h01, 5'd0, 32'h11, 1'b0, 1);

    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exec_unit.md
# exec_unit

Parametrised execution unit, successor to the single-cycle combinational ALU. It has a configurable datapath width and registered results behind a valid/ready handshake. It adds an iterative multiply/divide path (one bit per cycle) alongside the single-cycle ALU operations. It sits between the issue stage and writeback, with one operation in flight at a time.

## Interface
- `WIDTH`, 32: datapath width; must be a power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `i_clk` in 1: clock, all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: request valid.
- `o_ready` out 1: unit can accept a request.
- `i_opcode` in 5: operation select.
- `i_wordA` in WIDTH: operand A.
- `i_wordB` in WIDTH: operand B.
- `i_shamt` in SHW: immediate shift / bit index.
- `o_valid` out 1: result valid.
- `i_ready` in 1: consumer accepts the result.
- `o_result` out WIDTH: registered result.
- `o_illegal` out 1: qualified by `o_valid`; opcode was undefined.

## Operation
- A request is accepted on an edge where `i_valid && o_ready`. Operands and opcode are captured on that edge; inputs are don't-care afterwards.
- Opcodes 0x00–0x0F: ADD, SUB, AND, OR, NOR, XOR, SLL, SRL, SRA, SLT, SLTU, SETB, CLRB, SLLV, SRLV, SRAV, in that order.
  - Semantics are unchanged from the existing ALU, applied at WIDTH bits.
  - Immediate forms use `i_shamt`. Variable forms use `i_wordB[SHW-1:0]`.
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU produce a zero-extended 0 or 1.
- Opcodes 0x10–0x13, handled by the iterative path:
  - 0x10 MUL: low WIDTH bits of the unsigned 2·WIDTH product.
  - 0x11 MULHU: high WIDTH bits of the same product.
  - 0x12 DIVU: unsigned quotient.
  - 0x13 REMU: unsigned remainder.
- Divide by zero: DIVU returns all ones and REMU returns A. No flag is raised.
- Opcodes 0x14–0x1F: result 0, `o_illegal=1`, single-cycle timing.
- State machine:
  - IDLE:
    - Accept an ALU or illegal opcode → DONE.
    - Accept an MDU opcode → BUSY, with the bit counter loaded to WIDTH−1.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. When the counter reaches 0 → DONE.
  - DONE: hold `o_valid`, `o_result` and `o_illegal` stable. When `i_ready` is high → IDLE.
- `o_ready = (state == IDLE)`. There is no accept in DONE, even while `i_ready` is high; issue stalls one bubble.
- Reset values:
  - state IDLE.
  - `o_valid=0`, `o_result=0`, `o_illegal=0`, `o_ready=1` (the cycle after reset).
  - Counter 0.
- Reset mid-operation: a BUSY or DONE operation is discarded and no result is emitted. The unit is in IDLE on the edge after `i_rst` is sampled high.
- `i_valid` while BUSY: ignored. The requester must hold it, per the standard valid/ready rule.

## Timing
- Accept on edge N:
  - ALU or illegal op: `o_valid` high after edge N+1.
  - MDU op: `o_valid` high after edge N+WIDTH+1 (WIDTH BUSY cycles). For WIDTH=32 that is 33 cycles.
- Result handshake completes on the first edge with `o_valid && i_ready`. `o_valid` drops after that edge.
- Minimum issue interval: 2 cycles for ALU ops; WIDTH+2 cycles for MDU ops.
- Outputs are registered; there is no combinational path from inputs to outputs except `i_rst`.

## Structure
- `exec_pkg` holds:
  - `exec_op_e` (5-bit opcode enum, including the ALUOP_* values 0x00–0x0F).
  - `exec_state_e` (IDLE, BUSY, DONE).
  - The MDU opcode range constants.
- Sub-module `mdu_iter` contains the multiply/divide core: accumulator and shifting operand registers, bit counter, a `start` input and a `done` output.
- `exec_unit` holds the FSM, the single-cycle ALU case statement and the output registers.

## Test plan
- Sweep opcodes, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → 0 after 1 cycle.
  - SRA 0x80000000, shamt 4 → 0xF8000000.
  - SLT −1,1 → 1; SLTU −1,1 → 0.
  - CLRB 0xFF, shamt 0 → 0xFE.
- Multiply, one request per operation:
  - MUL 0x00010000·0x00010000 → 0 and MULHU → 1. Each `o_valid` arrives exactly 33 cycles after accept.
  - MUL 7·6 → 42.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Back-pressure: hold `i_ready=0` for 10 cycles after `o_valid` rises on ADD 3+4. `o_result` stays 7, `o_valid` stays 1, `o_ready` stays 0, and the held `i_valid` is not accepted until the cycle after release.
- Reset mid-op: start DIVU, then assert `i_rst` at cycle 10. No `o_valid` appears. `o_ready=1` the next cycle, and a following ADD 1+1 returns 2 after 1 cycle.
- Illegal opcode 0x1A: `o_valid` after 1 cycle with `o_result=0` and `o_illegal=1`. The next legal op returns `o_illegal=0`.
